// File: rtl/pipe_test_pkg.sv
// Shared constants for the pipe test pattern generator and checker:
// data width, LFSR seed/taps, counter seed and the pattern-mode encoding.
package pipe_test_pkg;

  localparam int DATA_W = 16;

  localparam logic [31:0]       LFSR_SEED = 32'h0000_0001;
  localparam int                LFSR_TAP_A = 31;
  localparam int                LFSR_TAP_B = 21;
  localparam int                LFSR_TAP_C = 1;
  localparam int                LFSR_TAP_D = 0;
  localparam logic [DATA_W-1:0] CNT_SEED  = 16'h0001;

  typedef enum logic {
    MODE_LFSR = 1'b0,
    MODE_CNT  = 1'b1
  } mode_e;

  typedef enum logic {
    TRK_IDLE  = 1'b0,
    TRK_BLOCK = 1'b1
  } trk_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/pipe_fifo.sv
// Synchronous first-word-fall-through buffer: the head word is always visible
// on rdata_o, and count_o reports the current occupancy.
module pipe_fifo
  import pipe_test_pkg::*;
#(
  parameter int FIFO_DEPTH = 1024,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [AW:0]       count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (do_push && !do_pop)
      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push)
      count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (clear_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pipe_out_source.sv
// Test-pattern source for a host pipe-out port: generates LFSR or counter
// words into a buffer and tracks block-throttled host reads.
module pipe_out_source
  import pipe_test_pkg::*;
#(
  parameter int BLOCK_WORDS = 256,
  parameter int FIFO_DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              mode,
  input  logic              gen_en,
  input  logic              pipe_out_read,
  output logic [DATA_W-1:0] pipe_out_data,
  output logic              pipe_out_ready,
  output logic [15:0]       underflow_count,
  output logic [31:0]       words_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(BLOCK_WORDS);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]        sync_q;
  logic              gen_live;
  mode_e             mode_q;
  logic [31:0]       lfsr_q;
  logic [DATA_W-1:0] cnt_q, gen_word;
  trk_e              state_q, state_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0] data_q, head;
  logic [15:0]       uf_q;
  logic [31:0]       ws_q;
  logic              ready_q, ready_d;
  logic              push, pop, full, empty;
  logic [AW:0]       occ, occ_d;

  assign gen_live = sync_q[1];
  assign push     = gen_en && !clear && gen_live && !full;
  assign pop      = pipe_out_read && !clear && !empty;
  assign gen_word = (mode_q == MODE_CNT) ? cnt_q : lfsr_q[DATA_W-1:0];

  pipe_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (clear),
    .push_i  (push),
    .wdata_i (gen_word),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (occ),
    .full_o  (full),
    .empty_o (empty)
  );

  // Reset release is retimed so generation never starts on the release edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], 1'b1};
  end

  // Mode is latched only while restarting, so buffered words keep their pattern.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_LFSR;
      lfsr_q <= LFSR_SEED;
      cnt_q  <= CNT_SEED;
    end else if (clear || !gen_live) begin
      mode_q <= mode_e'(mode);
      lfsr_q <= LFSR_SEED;
      cnt_q  <= CNT_SEED;
    end else if (push) begin
      if (mode_q == MODE_CNT) cnt_q  <= cnt_q + 16'd1;
      else                    lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  // Only reads that actually deliver a word consume block credit.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    occ_d   = occ;
    if (clear) begin
      state_d = TRK_IDLE;
      rem_d   = '0;
      occ_d   = '0;
    end else begin
      if (push && !pop) occ_d = occ + (AW+1)'(1);
      if (pop && !push) occ_d = occ - (AW+1)'(1);
      if (pop) begin
        case (state_q)
          TRK_IDLE: begin
            state_d = TRK_BLOCK;
            rem_d   = RW'(BLOCK_WORDS - 1);
          end
          TRK_BLOCK: begin
            rem_d = rem_q - RW'(1);
            if (rem_q == RW'(1)) state_d = TRK_IDLE;
          end
          default: state_d = TRK_IDLE;
        endcase
      end
    end
    ready_d = ({1'b0, occ_d} >= ((AW+2)'(rem_d) + (AW+2)'(BLOCK_WORDS)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TRK_IDLE;
      rem_q   <= '0;
      ready_q <= 1'b0;
      data_q  <= '0;
      uf_q    <= '0;
      ws_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ready_q <= ready_d;
      if (clear) begin
        data_q <= '0;
        uf_q   <= '0;
        ws_q   <= '0;
      end else if (pop) begin
        data_q <= head;
        ws_q   <= ws_q + 32'd1;
      end else if (pipe_out_read) begin
        uf_q <= sat_inc16(uf_q);
      end
    end
  end

  assign pipe_out_data   = data_q;
  assign pipe_out_ready  = ready_q;
  assign underflow_count = uf_q;
  assign words_sent      = ws_q;

endmodule

// File: tb/tb_pipe_out_source.sv
// Bench for pipe_out_source: reference model with a word scoreboard, a vector
// table for the short sequences, and directed multi-cycle corner cases.
module tb_pipe_out_source;

  localparam int BW    = 256;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset_n, clear, mode, gen_en, pipe_out_read;
  logic [15:0] pipe_out_data, underflow_count;
  logic        pipe_out_ready;
  logic [31:0] words_sent;

  always #5 clk = ~clk;

  pipe_out_source #(.BLOCK_WORDS(BW), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .clear           (clear),
    .mode            (mode),
    .gen_en          (gen_en),
    .pipe_out_read   (pipe_out_read),
    .pipe_out_data   (pipe_out_data),
    .pipe_out_ready  (pipe_out_ready),
    .underflow_count (underflow_count),
    .words_sent      (words_sent)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] sb_q[$];
  int          m_rem;
  logic [15:0] m_data, m_uf, m_cnt;
  logic [31:0] m_ws, m_lfsr;
  logic        m_rdy, m_mode;

  typedef struct {
    logic        rd, ge, clr, md;
    logic [15:0] d, uf;
    logic [31:0] ws;
    logic        rdy;
  } vec_t;
  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reseed();
    sb_q.delete();
    m_rem  = 0;
    m_data = 16'h0000;
    m_uf   = 16'h0000;
    m_ws   = 32'd0;
    m_rdy  = 1'b0;
    m_lfsr = 32'h0000_0001;
    m_cnt  = 16'h0001;
    m_mode = mode;
  endtask

  task automatic model_edge(input logic rd, input logic ge, input logic clr);
    logic        can_pop, can_push;
    logic [15:0] w;
    if (clr) begin
      model_reseed();
      return;
    end
    can_pop  = rd && (sb_q.size() > 0);
    can_push = ge && (sb_q.size() < DEPTH);
    if (rd && !can_pop && m_uf != 16'hFFFF) m_uf = m_uf + 16'd1;
    if (can_pop) begin
      m_data = sb_q.pop_front();
      m_ws   = m_ws + 32'd1;
      m_rem  = (m_rem == 0) ? BW - 1 : m_rem - 1;
    end
    if (can_push) begin
      w = m_mode ? m_cnt : m_lfsr[15:0];
      sb_q.push_back(w);
      if (m_mode) m_cnt = m_cnt + 16'd1;
      else m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
    end
    m_rdy = (sb_q.size() >= m_rem + BW);
  endtask

  task automatic step(input logic rd, input logic ge, input logic clr);
    @(negedge clk);
    pipe_out_read = rd;
    gen_en        = ge;
    clear         = clr;
    @(posedge clk);
    model_edge(rd, ge, clr);
    #1;
    check("data", 32'(pipe_out_data), 32'(m_data));
    check("ready", 32'(pipe_out_ready), 32'(m_rdy));
    check("underflow", 32'(underflow_count), 32'(m_uf));
    check("words_sent", words_sent, m_ws);
    check("occupancy", 32'(dut.u_fifo.count_o), 32'(sb_q.size()));
  endtask

  task automatic do_reset(input logic md);
    @(negedge clk);
    #2;
    reset_n       = 1'b0;
    mode          = md;
    gen_en        = 1'b1;
    pipe_out_read = 1'b0;
    clear         = 1'b0;
    #1;
    check("rst_data", 32'(pipe_out_data), 32'h0);
    check("rst_ready", 32'(pipe_out_ready), 32'h0);
    check("rst_underflow", 32'(underflow_count), 32'h0);
    check("rst_words_sent", words_sent, 32'h0);
    check("rst_occupancy", 32'(dut.u_fifo.count_o), 32'h0);
    model_reseed();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("no_push_on_release_edge", 32'(dut.u_fifo.count_o), 32'h0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd0, 32'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0, 32'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 16'd0, 32'd1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0003, 16'd0, 32'd2, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0006, 16'd0, 32'd3, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h000D, 16'd0, 32'd4, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd0, 32'd0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd1, 32'd0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd2, 32'd0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd3, 32'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd0, 32'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'd0, 32'd0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 16'd0, 32'd1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0003, 16'd0, 32'd2, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'd0, 32'd0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'd0, 32'd0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 16'd0, 32'd1, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 16'd0, 32'd2, 1'b0};

    reset_n       = 1'b0;
    clear         = 1'b0;
    mode          = 1'b1;
    gen_en        = 1'b0;
    pipe_out_read = 1'b0;

    // Counter mode from reset: wait for a full block, then drain it.
    do_reset(1'b1);
    for (int n = 0; n < 400 && !pipe_out_ready; n++) step(1'b0, 1'b1, 1'b0);
    check("ready_rise", 32'(pipe_out_ready), 32'd1);
    for (int i = 0; i < BW; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check("block_seq", 32'(pipe_out_data), 32'(i + 1));
    end
    check("block_underflow", 32'(underflow_count), 32'd0);
    check("block_words_sent", words_sent, 32'd256);
    check("block_last", 32'(pipe_out_data), 32'h0100);

    // Vector table: LFSR words, underflow, clear priority, deferred mode change.
    for (int i = 0; i < 18; i++) begin
      mode = tbl[i].md;
      step(tbl[i].rd, tbl[i].ge, tbl[i].clr);
      check($sformatf("tbl%0d_data", i), 32'(pipe_out_data), 32'(tbl[i].d));
      check($sformatf("tbl%0d_underflow", i), 32'(underflow_count), 32'(tbl[i].uf));
      check($sformatf("tbl%0d_words_sent", i), words_sent, tbl[i].ws);
      check($sformatf("tbl%0d_ready", i), 32'(pipe_out_ready), 32'(tbl[i].rdy));
    end

    // Fill to 511, one read opens a block and ready must drop until refilled.
    mode = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    repeat (511) step(1'b0, 1'b1, 1'b0);
    check("fill511_ready", 32'(pipe_out_ready), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    check("block_open_ready", 32'(pipe_out_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check("block_hold_ready", 32'(pipe_out_ready), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0);
    check("block_refill_ready", 32'(pipe_out_ready), 32'd1);

    // Full buffer with concurrent push and pop for 2000 cycles.
    step(1'b0, 1'b0, 1'b1);
    repeat (DEPTH) step(1'b0, 1'b1, 1'b0);
    check("full_occupancy", 32'(dut.u_fifo.count_o), 32'(DEPTH));
    for (int i = 0; i < 2000; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check("stream_seq", 32'(pipe_out_data), 32'(i + 1));
      if (i > 0) check("stream_occupancy", 32'(dut.u_fifo.count_o), 32'(DEPTH - 1));
    end

    // Reset in the middle of a block, then restart from the seed.
    step(1'b0, 1'b0, 1'b1);
    repeat (300) step(1'b0, 1'b1, 1'b0);
    repeat (100) step(1'b1, 1'b0, 1'b0);
    check("midblock_words_sent", words_sent, 32'd100);
    check("midblock_data", 32'(pipe_out_data), 32'd100);
    do_reset(1'b1);
    for (int n = 0; n < 400 && !pipe_out_ready; n++) step(1'b0, 1'b1, 1'b0);
    check("restart_ready", 32'(pipe_out_ready), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    check("restart_first_word", 32'(pipe_out_data), 32'h0001);
    check("restart_words_sent", words_sent, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
